alu_sub_serial: RTL
===================

// Module: alu_sub_serial
// PURPOSE
//  Bit-serial, LSB-first subtractor for the ALU subtract opcode; the inverse of the add path.
//  Computes A - B over W cycles using one full-subtractor cell and one borrow flip-flop.
//  Uses the same op/en gating as the ALU add path. Handshake: start in, busy/done out.
//  Sits beside the add unit; the ALU output mux selects Doutsub when op == OP_SUB.
// PARAMETERS
//  W       3      operand width in bits (W >= 2)
//  OP_SUB  2'b11  op code that enables this unit
// PORTS
//  clk      in   1     single clock; all state updates on the rising edge
//  rst      in   1     synchronous, active-high reset
//  en       in   1     unit enable; low = hold all state (stall)
//  op       in   2     ALU opcode; the unit accepts start only when op == OP_SUB
//  start    in   1     request; sampled in IDLE only
//  A        in   W     minuend, latched on the accepted start
//  B        in   W     subtrahend, latched on the accepted start
//  busy     out  1     high while in SHIFT
//  done     out  1     one-cycle pulse when the result is valid
//  Doutsub  out  W     (A - B) mod 2^W; held until the next accepted start
//  Bw       out  1     final borrow: 1 when A < B unsigned; held with Doutsub
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, Doutsub=0, Bw=0;
//   count=0, borrow=0, shift registers cleared. Reset overrides en and start.
//  Reset mid-operation aborts the operation; no done is produced.
//  FSM with 2 states, IDLE and SHIFT.
//  IDLE:  if en & start & (op==OP_SUB):
//          sa<=A, sb<=B, borrow<=0, count<=0, res<=0, busy<=1 -> SHIFT
//         otherwise hold. Doutsub and Bw keep their last values.
//  SHIFT: on each edge with en=1:
//          d  = sa[0]^sb[0]^borrow
//          borrow <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow)
//          res <= {d, res[W-1:1]}; sa,sb shift right by 1; count<=count+1
//         on the edge where count==W-1 (the last bit):
//          Doutsub<={d,res[W-1:1]}, Bw<=borrow_next, done<=1, busy<=0 -> IDLE
//  en=0 in SHIFT: full stall; count, shift registers and borrow are frozen.
//   An en=0 at the last-bit edge delays done until the next edge with en=1.
//  done is high for exactly one cycle; on the next edge done<=0 regardless of en.
//  start, op, A and B are ignored while busy=1; no queuing.
//  Back-to-back: start is accepted in the cycle where done=1 (state is IDLE).
//  A and B are latched only on the accepted start; later changes to A or B have no effect.
//  Latency: start accepted at edge k, en held high -> done=1 after edge k+W.
//  Throughput: one result per W+1 cycles.
//  count width = clog2(W); no arithmetic overflow beyond mod-2^W wrap, signalled by Bw.
// TESTING
//  W=3, A=3,B=1 start, en=1 -> done after 3 shift edges; Doutsub=3'b010, Bw=0
//  A=1,B=3 -> Doutsub=3'b110, Bw=1; A=7,B=7 -> Doutsub=0, Bw=0; A=0,B=7 -> 3'b001, Bw=1
//  A=6,B=3, en=0 for 2 cycles after the 1st shift -> done 2 cycles late; Doutsub=3'b011
//  start with op=2'b10 -> no busy/done; start while busy with A=5 -> ignored, result unchanged
//  rst=1 during SHIFT -> next cycle busy=0, done=0, Doutsub=0, Bw=0; a new start then completes normally
//  Random A,B over 200 ops, including back-to-back starts -> Doutsub==(A-B)&7 and Bw==(A<B) every op

Source files
------------

// File: rtl/alu_sub_serial.sv
`default_nettype none
// ============================================================================
// Module  : alu_sub_serial
// Brief   : Bit-serial LSB-first subtractor (A - B) using one borrow flop.
// Revision: 1.0
// ============================================================================
module alu_sub_serial #(
  parameter int         W      = 3,
  parameter logic [1:0] OP_SUB = 2'b11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   op,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Doutsub,
  output logic         Bw
);

  localparam int            CW      = $clog2(W);
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);

  logic [0:0]    state_q,  state_d;
  logic [W-1:0]  sa_q,     sa_d;
  logic [W-1:0]  sb_q,     sb_d;
  logic [W-1:0]  res_q,    res_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] count_q,  count_d;
  logic          done_q,   done_d;
  logic [W-1:0]  dout_q,   dout_d;
  logic          bw_q,     bw_d;

  logic          diff_bit;
  logic          borrow_nx;
  logic [W-1:0]  res_nx;

  // Full-subtractor cell on the current LSBs.
  assign diff_bit  = sa_q[0] ^ sb_q[0] ^ borrow_q;
  assign borrow_nx = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
  assign res_nx    = {diff_bit, res_q[W-1:1]};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    bw_d     = bw_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start && (op == OP_SUB)) begin
            sa_d     = A;
            sb_d     = B;
            res_d    = '0;
            borrow_d = 1'b0;
            count_d  = '0;
            state_d  = S_SHIFT;
          end
        end
        S_SHIFT: begin
          borrow_d = borrow_nx;
          res_d    = res_nx;
          sa_d     = sa_q >> 1;
          sb_d     = sb_q >> 1;
          count_d  = count_q + CW'(1);
          if (count_q == LAST) begin
            dout_d  = res_nx;
            bw_d    = borrow_nx;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      bw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      bw_q     <= bw_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = done_q;
  assign Doutsub = dout_q;
  assign Bw      = bw_q;

endmodule
`default_nettype wire
